fp_align_seq: RTL and testbench

Multi-cycle exponent-alignment sequencer for the double-precision floating-point adder. It captures two operands as 11-bit exponent plus 53-bit significand (hidden bit included), picks the larger exponent, and drives that selection onto the 11-bit and 53-bit operand muxes. It then right-shifts the smaller significand one bit per cycle, accumulating a sticky bit, until both significands share the larger exponent. Outputs feed the significand adder and the normalizer.

---
 rtl/fp_align_seq_if.sv | 29 ++
 rtl/fp_align_seq.sv | 114 +++++++++++
 tb/tb_fp_align_seq.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/fp_align_seq_if.sv
// Operand capture and alignment result bundle between the adder front end
// and the exponent-alignment sequencer.
interface fp_align_seq_if #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 53
);
  logic             start;
  logic [EXP_W-1:0] exp_a;
  logic [EXP_W-1:0] exp_b;
  logic [MAN_W-1:0] man_a;
  logic [MAN_W-1:0] man_b;
  logic             busy;
  logic             done;
  logic             swap;
  logic [EXP_W-1:0] exp_out;
  logic [MAN_W-1:0] man_big;
  logic [MAN_W-1:0] man_small;
  logic             sticky;

  modport master (
    output start, exp_a, exp_b, man_a, man_b,
    input  busy, done, swap, exp_out, man_big, man_small, sticky
  );

  modport slave (
    input  start, exp_a, exp_b, man_a, man_b,
    output busy, done, swap, exp_out, man_big, man_small, sticky
  );
endinterface

// File: rtl/fp_align_seq.sv
// Exponent-alignment sequencer: selects the larger-exponent operand, then
// right-shifts the smaller significand one bit per cycle with a sticky bit.
module fp_align_seq #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 53
) (
  input  logic          clk,
  input  logic          reset,
  fp_align_seq_if.slave bus
);
  localparam int CNT_W = $clog2(MAN_W);

  typedef enum logic [1:0] {IDLE, COMPARE, SHIFT, DONE} state_t;

  state_t           state_reg, state_next;
  logic [EXP_W-1:0] lat_exp_a_reg, lat_exp_b_reg;
  logic [MAN_W-1:0] lat_man_a_reg, lat_man_b_reg;
  logic             swap_reg;
  logic [EXP_W-1:0] exp_out_reg;
  logic [MAN_W-1:0] man_big_reg, man_small_reg;
  logic             sticky_reg;
  logic [CNT_W-1:0] cnt_reg;

  logic             cmp_swap;
  logic [EXP_W-1:0] cmp_exp_big, cmp_exp_small, cmp_diff;
  logic [MAN_W-1:0] cmp_man_big, cmp_man_small;
  logic             cmp_sat;

  // Selection is computed from the latched copies so inputs may change freely.
  assign cmp_swap      = lat_exp_b_reg > lat_exp_a_reg;
  assign cmp_exp_big   = cmp_swap ? lat_exp_b_reg : lat_exp_a_reg;
  assign cmp_exp_small = cmp_swap ? lat_exp_a_reg : lat_exp_b_reg;
  assign cmp_diff      = cmp_exp_big - cmp_exp_small;
  assign cmp_sat       = cmp_diff >= EXP_W'(MAN_W);

  generate
    for (genvar gi = 0; gi < MAN_W; gi++) begin : g_man_mux
      assign cmp_man_big[gi]   = cmp_swap ? lat_man_b_reg[gi] : lat_man_a_reg[gi];
      assign cmp_man_small[gi] = cmp_swap ? lat_man_a_reg[gi] : lat_man_b_reg[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (bus.start) state_next = COMPARE;
      COMPARE: state_next = (cmp_diff == '0 || cmp_sat) ? DONE : SHIFT;
      // Exit on the cycle the counter steps from 1 to 0.
      SHIFT:   if (cnt_reg == CNT_W'(1)) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      lat_exp_a_reg <= '0;
      lat_exp_b_reg <= '0;
      lat_man_a_reg <= '0;
      lat_man_b_reg <= '0;
      swap_reg      <= 1'b0;
      exp_out_reg   <= '0;
      man_big_reg   <= '0;
      man_small_reg <= '0;
      sticky_reg    <= 1'b0;
      cnt_reg       <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            lat_exp_a_reg <= bus.exp_a;
            lat_exp_b_reg <= bus.exp_b;
            lat_man_a_reg <= bus.man_a;
            lat_man_b_reg <= bus.man_b;
          end
        end
        COMPARE: begin
          swap_reg    <= cmp_swap;
          exp_out_reg <= cmp_exp_big;
          man_big_reg <= cmp_man_big;
          // A shift of MAN_W or more empties the significand into sticky.
          if (cmp_sat) begin
            man_small_reg <= '0;
            sticky_reg    <= |cmp_man_small;
            cnt_reg       <= '0;
          end else begin
            man_small_reg <= cmp_man_small;
            sticky_reg    <= 1'b0;
            cnt_reg       <= cmp_diff[CNT_W-1:0];
          end
        end
        SHIFT: begin
          sticky_reg    <= sticky_reg | man_small_reg[0];
          man_small_reg <= man_small_reg >> 1;
          cnt_reg       <= cnt_reg - CNT_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_reg != IDLE);
  assign bus.done      = (state_reg == DONE);
  assign bus.swap      = swap_reg;
  assign bus.exp_out   = exp_out_reg;
  assign bus.man_big   = man_big_reg;
  assign bus.man_small = man_small_reg;
  assign bus.sticky    = sticky_reg;
endmodule

// File: tb/tb_fp_align_seq.sv
// Directed bench for fp_align_seq: cycle n means the n-th falling edge after
// the rising edge that samples start.
module tb_fp_align_seq;
  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad   = 0;
  int   done_at;
  int   pulses;
  int   seen_done;

  fp_align_seq_if #(.EXP_W(11), .MAN_W(53)) ifc ();

  fp_align_seq #(.EXP_W(11), .MAN_W(53)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (ifc.slave)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic launch(input logic [10:0] ea, input logic [10:0] eb,
                        input logic [52:0] ma, input logic [52:0] mb);
    @(negedge clk);
    ifc.exp_a = ea; ifc.exp_b = eb; ifc.man_a = ma; ifc.man_b = mb;
    ifc.start = 1'b1;
    @(negedge clk);
    ifc.start = 1'b0;
    ifc.exp_a = 11'h7FF; ifc.exp_b = 11'h7FF;
    ifc.man_a = '1;      ifc.man_b = '1;
  endtask

  // Returns the cycle of the first done pulse, 0 if none within the limit.
  task automatic wait_done(input int limit, output int at);
    at = 0;
    for (int n = 1; n <= limit; n++) begin
      if (n > 1) @(negedge clk);
      if (ifc.done) begin
        at = n;
        break;
      end
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_busy"},  64'(ifc.busy),      64'd0);
    chk({tag, "_done"},  64'(ifc.done),      64'd0);
    chk({tag, "_swap"},  64'(ifc.swap),      64'd0);
    chk({tag, "_exp"},   64'(ifc.exp_out),   64'd0);
    chk({tag, "_big"},   64'(ifc.man_big),   64'd0);
    chk({tag, "_small"}, 64'(ifc.man_small), 64'd0);
    chk({tag, "_stk"},   64'(ifc.sticky),    64'd0);
  endtask

  initial begin
    reset = 1'b1;
    ifc.start = 1'b0;
    ifc.exp_a = '0; ifc.exp_b = '0; ifc.man_a = '0; ifc.man_b = '0;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;

    // Equal exponents
    launch(11'd1023, 11'd1023, 53'd321, 53'd12);
    wait_done(60, done_at);
    chk("eq_at", 64'(done_at), 64'd2);
    chk("eq_swap", 64'(ifc.swap), 64'd0);
    chk("eq_exp", 64'(ifc.exp_out), 64'd1023);
    chk("eq_big", 64'(ifc.man_big), 64'd321);
    chk("eq_small", 64'(ifc.man_small), 64'd12);
    chk("eq_stk", 64'(ifc.sticky), 64'd0);
    $display("eq: done_at=%0d", done_at);
    @(negedge clk);
    chk("eq_busy_fall", 64'(ifc.busy), 64'd0);
    chk("eq_done_1cyc", 64'(ifc.done), 64'd0);

    // A larger by 3
    launch(11'd1026, 11'd1023, 53'h10000000000000, 53'h1000000000000D);
    wait_done(60, done_at);
    chk("a3_at", 64'(done_at), 64'd5);
    chk("a3_swap", 64'(ifc.swap), 64'd0);
    chk("a3_exp", 64'(ifc.exp_out), 64'd1026);
    chk("a3_big", 64'(ifc.man_big), 64'h10000000000000);
    chk("a3_small", 64'(ifc.man_small), 64'h02000000000001);
    chk("a3_stk", 64'(ifc.sticky), 64'd1);
    $display("a3: done_at=%0d", done_at);

    // B larger by 1; start accepted in the IDLE cycle right after DONE
    launch(11'd1000, 11'd1001, 53'h1FFFFFFFFFFFFF, 53'h10000000000000);
    wait_done(60, done_at);
    chk("b1_at", 64'(done_at), 64'd3);
    chk("b1_swap", 64'(ifc.swap), 64'd1);
    chk("b1_exp", 64'(ifc.exp_out), 64'd1001);
    chk("b1_big", 64'(ifc.man_big), 64'h10000000000000);
    chk("b1_small", 64'(ifc.man_small), 64'h0FFFFFFFFFFFFF);
    chk("b1_stk", 64'(ifc.sticky), 64'd1);
    $display("b1: done_at=%0d", done_at);

    // Saturation, nonzero and zero shifted-out significand
    launch(11'd2000, 11'd10, 53'h10000000000000, 53'd1);
    wait_done(60, done_at);
    chk("sat_at", 64'(done_at), 64'd2);
    chk("sat_exp", 64'(ifc.exp_out), 64'd2000);
    chk("sat_big", 64'(ifc.man_big), 64'h10000000000000);
    chk("sat_small", 64'(ifc.man_small), 64'd0);
    chk("sat_stk", 64'(ifc.sticky), 64'd1);
    $display("sat1: done_at=%0d", done_at);
    launch(11'd2000, 11'd10, 53'h10000000000000, 53'd0);
    wait_done(60, done_at);
    chk("sat0_at", 64'(done_at), 64'd2);
    chk("sat0_stk", 64'(ifc.sticky), 64'd0);
    $display("sat0: done_at=%0d", done_at);

    // Largest non-saturating difference (52) and smallest saturating one (53)
    launch(11'd1075, 11'd1023, 53'h10000000000000, 53'h1FFFFFFFFFFFFF);
    wait_done(80, done_at);
    chk("d52_at", 64'(done_at), 64'd54);
    chk("d52_small", 64'(ifc.man_small), 64'd1);
    chk("d52_stk", 64'(ifc.sticky), 64'd1);
    $display("d52: done_at=%0d", done_at);
    launch(11'd1023, 11'd1076, 53'h1FFFFFFFFFFFFF, 53'h10000000000000);
    wait_done(80, done_at);
    chk("d53_at", 64'(done_at), 64'd2);
    chk("d53_swap", 64'(ifc.swap), 64'd1);
    chk("d53_small", 64'(ifc.man_small), 64'd0);
    chk("d53_stk", 64'(ifc.sticky), 64'd1);
    $display("d53: done_at=%0d", done_at);

    // start pulsed while busy must be ignored
    launch(11'd1026, 11'd1023, 53'h10000000000000, 53'h1000000000000D);
    pulses = 0;
    done_at = 0;
    for (int n = 1; n <= 8; n++) begin
      if (n > 1) @(negedge clk);
      if (n == 2 || n == 4) begin
        ifc.start = 1'b1;
        ifc.exp_a = 11'd5; ifc.exp_b = 11'd900;
        ifc.man_a = 53'h0ABCDEF; ifc.man_b = 53'h123456;
      end else begin
        ifc.start = 1'b0;
      end
      if (ifc.done) begin
        pulses++;
        done_at = n;
      end
      if (n == 6) chk("bz_busy6", 64'(ifc.busy), 64'd0);
    end
    ifc.start = 1'b0;
    chk("bz_pulses", 64'(pulses), 64'd1);
    chk("bz_at", 64'(done_at), 64'd5);
    chk("bz_swap", 64'(ifc.swap), 64'd0);
    chk("bz_exp", 64'(ifc.exp_out), 64'd1026);
    chk("bz_small", 64'(ifc.man_small), 64'h02000000000001);
    chk("bz_stk", 64'(ifc.sticky), 64'd1);
    $display("busy_start: pulses=%0d done_at=%0d", pulses, done_at);

    // Reset in the middle of a 40-bit shift
    launch(11'd1063, 11'd1023, 53'h10000000000000, 53'h1FFFFFFFFFFFFF);
    seen_done = 0;
    for (int n = 1; n <= 10; n++) begin
      if (n > 1) @(negedge clk);
      if (ifc.done) seen_done++;
    end
    chk("mid_busy", 64'(ifc.busy), 64'd1);
    reset = 1'b1;
    #1;
    chk_zero("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ifc.done) seen_done++;
    end
    chk("mid_nodone", 64'(seen_done), 64'd0);
    $display("reset_mid: done_pulses=%0d", seen_done);
    launch(11'd1023, 11'd1023, 53'd321, 53'd12);
    wait_done(60, done_at);
    chk("post_at", 64'(done_at), 64'd2);
    chk("post_small", 64'(ifc.man_small), 64'd12);
    $display("post_reset: done_at=%0d", done_at);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
